// File: rtl/ntt_pkg.sv
// ntt_pkg: shared definitions for the iterative NTT blocks.
//   state_t  : core sequencing states (LOAD, COMPUTE, UNLOAD)
//   bitrev   : reverse the low 'width' bits of a value
//   mod_add  : (a + b) mod q for a, b < q
//   mod_sub  : (a - b) mod q for a, b < q
// Arithmetic helpers work on 32-bit containers so any block with a
// coefficient width up to 32 bits can reuse them through casts.
package ntt_pkg;

    typedef enum logic [1:0] {
        ST_LOAD    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_UNLOAD  = 2'd2
    } state_t;

    function automatic logic [31:0] bitrev(input logic [31:0] value, input int width);
        logic [31:0] r;
        r = '0;
        for (int k = 0; k < 32; k++) begin
            if (k < width) begin
                r[k] = value[width-1-k];
            end
        end
        return r;
    endfunction

    // One extra bit of headroom before the conditional subtract.
    function automatic logic [31:0] mod_add(input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] q);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, q}) begin
            s = s - {1'b0, q};
        end
        return s[31:0];
    endfunction

    // Equivalent to (a - b + q) mod q without ever going negative.
    function automatic logic [31:0] mod_sub(input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] q);
        logic [31:0] d;
        if (a >= b) begin
            d = a - b;
        end else begin
            d = a + (q - b);
        end
        return d;
    endfunction

endpackage

// File: rtl/ntt_iter_core_bf_unit.sv
// ntt_bf_unit: combinational radix-2 Cooley-Tukey butterfly over Z_q.
//   i_a, i_b : operands (< i_q)
//   i_w      : twiddle factor (< i_q)
//   i_q      : modulus, >= 2
//   o_a      : (a + w*b) mod q
//   o_b      : (a - w*b) mod q
module ntt_bf_unit
    import ntt_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic [DATA_W-1:0] i_w,
    input  logic [DATA_W-1:0] i_q,
    output logic [DATA_W-1:0] o_a,
    output logic [DATA_W-1:0] o_b
);

    logic [2*DATA_W-1:0] w_prod;
    logic [DATA_W-1:0]   w_t;

    always_comb begin
        // Full double-width product, then a single reduction.
        w_prod = {{DATA_W{1'b0}}, i_w} * {{DATA_W{1'b0}}, i_b};
        w_t    = DATA_W'(w_prod % {{DATA_W{1'b0}}, i_q});
        o_a    = DATA_W'(mod_add(32'(i_a), 32'(w_t), 32'(i_q)));
        o_b    = DATA_W'(mod_sub(32'(i_a), 32'(w_t), 32'(i_q)));
    end

endmodule

// File: rtl/ntt_iter_core.sv
// ntt_iter_core: sequential radix-2 DIT NTT/INTT engine over Z_q.
// Loads N coefficients (natural order) into a bit-reversed register file,
// runs (N/2)*log2(N) in-place butterflies one per cycle, then streams the
// N results out in natural order, optionally scaled by n^-1.
// Ports:
//   i_clk, i_rst_n          : clock, synchronous active-low reset
//   i_in_valid/o_in_ready   : input handshake (ready only while loading)
//   i_in_data               : coefficient, < i_mod
//   i_mod, i_omegas         : modulus and twiddles w^k, k=0..N/2-1
//   i_inverse, i_n_inv      : inverse mode and N^-1 mod q
//   o_out_valid/i_out_ready : output handshake
//   o_out_data, o_out_last  : result sample, marks sample N-1
//   o_busy                  : computing or unloading
// Configuration inputs are captured on the first input handshake of a frame.
module ntt_iter_core
    import ntt_pkg::*;
#(
    parameter  int N      = 8,
    parameter  int DATA_W = 8,
    localparam int LOG_N  = $clog2(N)
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_in_valid,
    output logic                         o_in_ready,
    input  logic [DATA_W-1:0]            i_in_data,
    input  logic [DATA_W-1:0]            i_mod,
    input  logic [N/2-1:0][DATA_W-1:0]   i_omegas,
    input  logic                         i_inverse,
    input  logic [DATA_W-1:0]            i_n_inv,
    output logic                         o_out_valid,
    input  logic                         i_out_ready,
    output logic [DATA_W-1:0]            o_out_data,
    output logic                         o_out_last,
    output logic                         o_busy
);

    localparam int SW = $clog2(LOG_N);   // stage counter width
    localparam int PW = LOG_N - 1;       // pair counter / twiddle index width
    localparam logic [SW-1:0]    LAST_STAGE = SW'(LOG_N - 1);
    localparam logic [LOG_N-1:0] LAST_IDX   = LOG_N'(N - 1);

    state_t r_state, w_state_next;

    logic [LOG_N-1:0] r_load_cnt;
    logic [SW-1:0]    r_stage;
    logic [PW-1:0]    r_pair;
    logic [LOG_N-1:0] r_idx;

    logic [DATA_W-1:0]          r_mod;
    logic [DATA_W-1:0]          r_n_inv;
    logic                       r_inverse;
    logic [N/2-1:0][DATA_W-1:0] r_omegas;

    logic w_in_hs;
    logic w_bf_en;
    logic w_compute_done;
    logic [LOG_N-1:0] w_load_addr;

    logic [LOG_N-1:0] w_pair_ext;
    logic [LOG_N-1:0] w_half;
    logic [LOG_N-1:0] w_j;
    logic [LOG_N-1:0] w_grp;
    logic [SW:0]      w_shift_up;
    logic [SW-1:0]    w_shift_tw;
    logic [LOG_N-1:0] w_idx_a;
    logic [LOG_N-1:0] w_idx_b;
    logic [PW-1:0]    w_tw_idx;

    logic [DATA_W-1:0] w_buf [N];
    logic [DATA_W-1:0] w_a, w_b, w_w;
    logic [DATA_W-1:0] w_a_new, w_b_new;

    logic [DATA_W-1:0]   w_rd;
    logic [2*DATA_W-1:0] w_scale_prod;
    logic [DATA_W-1:0]   w_scaled;

    assign w_in_hs        = i_in_valid && (r_state == ST_LOAD);
    assign w_bf_en        = (r_state == ST_COMPUTE);
    assign w_compute_done = (r_stage == LAST_STAGE) && (&r_pair);
    assign w_load_addr    = LOG_N'(bitrev(32'(r_load_cnt), LOG_N));

    // Butterfly addressing for pair p in stage s (half = 2^s):
    //   j = p mod half, group = p / half
    //   i = group*2*half + j, partner = i + half
    //   twiddle index = j * N/(2*half) = j << (LOG_N-1-s)
    always_comb begin
        w_pair_ext = {1'b0, r_pair};
        w_half     = LOG_N'(1) << r_stage;
        w_j        = w_pair_ext & (w_half - LOG_N'(1));
        w_grp      = w_pair_ext >> r_stage;
        w_shift_up = {1'b0, r_stage} + (SW+1)'(1);
        w_idx_a    = (w_grp << w_shift_up) | w_j;
        w_idx_b    = w_idx_a | w_half;
        w_shift_tw = LAST_STAGE - r_stage;
        w_tw_idx   = PW'(w_j << w_shift_tw);
    end

    assign w_a = w_buf[w_idx_a];
    assign w_b = w_buf[w_idx_b];
    assign w_w = r_omegas[w_tw_idx];

    ntt_bf_unit #(
        .DATA_W (DATA_W)
    ) u_bf (
        .i_a (w_a),
        .i_b (w_b),
        .i_w (w_w),
        .i_q (r_mod),
        .o_a (w_a_new),
        .o_b (w_b_new)
    );

    // Register-file buffer: both butterfly operands are read and written
    // back in the same cycle, so each cell is an independent register.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_buf
            logic [DATA_W-1:0] r_cell;
            always_ff @(posedge i_clk) begin
                if (w_in_hs && (w_load_addr == LOG_N'(gi))) begin
                    r_cell <= i_in_data;
                end else if (w_bf_en && (w_idx_a == LOG_N'(gi))) begin
                    r_cell <= w_a_new;
                end else if (w_bf_en && (w_idx_b == LOG_N'(gi))) begin
                    r_cell <= w_b_new;
                end
            end
            assign w_buf[gi] = r_cell;
        end
    endgenerate

    // Output path: optional scaling by N^-1 for the inverse transform.
    always_comb begin
        w_rd         = w_buf[r_idx];
        w_scale_prod = {{DATA_W{1'b0}}, w_rd} * {{DATA_W{1'b0}}, r_n_inv};
        w_scaled     = DATA_W'(w_scale_prod % {{DATA_W{1'b0}}, r_mod});
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and outputs
    always_comb begin
        w_state_next = r_state;
        o_in_ready   = 1'b0;
        o_out_valid  = 1'b0;
        o_out_last   = 1'b0;
        o_out_data   = '0;
        o_busy       = 1'b0;
        case (r_state)
            ST_LOAD: begin
                o_in_ready = 1'b1;
                if (i_in_valid && (r_load_cnt == LAST_IDX)) begin
                    w_state_next = ST_COMPUTE;
                end
            end
            ST_COMPUTE: begin
                o_busy = 1'b1;
                if (w_compute_done) begin
                    w_state_next = ST_UNLOAD;
                end
            end
            ST_UNLOAD: begin
                o_busy      = 1'b1;
                o_out_valid = 1'b1;
                o_out_data  = r_inverse ? w_scaled : w_rd;
                o_out_last  = (r_idx == LAST_IDX);
                if (i_out_ready && (r_idx == LAST_IDX)) begin
                    w_state_next = ST_LOAD;
                end
            end
            default: begin
                w_state_next = ST_LOAD;
            end
        endcase
    end

    // Counters. Load and unload counters are exactly LOG_N bits wide, so
    // they wrap back to zero on the final sample of a frame.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_load_cnt <= '0;
            r_stage    <= '0;
            r_pair     <= '0;
            r_idx      <= '0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    r_stage <= '0;
                    r_pair  <= '0;
                    if (w_in_hs) begin
                        r_load_cnt <= r_load_cnt + LOG_N'(1);
                    end
                end
                ST_COMPUTE: begin
                    r_pair <= r_pair + PW'(1);
                    if (&r_pair) begin
                        r_stage <= (r_stage == LAST_STAGE) ? '0 : r_stage + SW'(1);
                    end
                end
                ST_UNLOAD: begin
                    if (i_out_ready) begin
                        r_idx <= r_idx + LOG_N'(1);
                    end
                end
                default: begin
                    r_load_cnt <= '0;
                end
            endcase
        end
    end

    // Frame configuration, captured with the first coefficient.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_mod     <= '0;
            r_n_inv   <= '0;
            r_inverse <= 1'b0;
            r_omegas  <= '0;
        end else if (w_in_hs && (r_load_cnt == '0)) begin
            r_mod     <= i_mod;
            r_n_inv   <= i_n_inv;
            r_inverse <= i_inverse;
            r_omegas  <= i_omegas;
        end
    end

endmodule

// File: tb/tb_ntt_iter_core.sv
module tb_ntt_iter_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // N=8 instance signals
    logic            iv8, ir8, ov8, or8, ol8, bz8, inv8;
    logic [7:0]      id8, mod8, ninv8, od8;
    logic [3:0][7:0] om8;
    // N=4 instance signals
    logic            iv4, ir4, ov4, or4, ol4, bz4, inv4;
    logic [7:0]      id4, mod4, ninv4, od4;
    logic [1:0][7:0] om4;

    ntt_iter_core #(.N(8), .DATA_W(8)) dut8 (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(iv8), .o_in_ready(ir8),
        .i_in_data(id8), .i_mod(mod8), .i_omegas(om8), .i_inverse(inv8),
        .i_n_inv(ninv8), .o_out_valid(ov8), .i_out_ready(or8),
        .o_out_data(od8), .o_out_last(ol8), .o_busy(bz8)
    );

    ntt_iter_core #(.N(4), .DATA_W(8)) dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(iv4), .o_in_ready(ir4),
        .i_in_data(id4), .i_mod(mod4), .i_omegas(om4), .i_inverse(inv4),
        .i_n_inv(ninv4), .o_out_valid(ov4), .i_out_ready(or4),
        .o_out_data(od4), .o_out_last(ol4), .o_busy(bz4)
    );

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboards: {last, data}
    logic [8:0] q8[$];
    logic [8:0] q4[$];
    int hs8 = 0;
    int hs4 = 0;
    bit bp8 = 1'b0;

    logic [7:0] vec8 [8];
    logic [7:0] exp8 [8];
    logic [7:0] vec4 [4];
    logic [7:0] exp4 [4];

    // Output backpressure for the N=8 instance, changed just after posedge
    initial begin
        or8 = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            or8 = bp8 ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor, N=8
    logic       pstall8 = 1'b0;
    logic       pv8     = 1'b0;
    logic [7:0] pd8;
    logic       pl8;
    always @(negedge clk) begin
        logic [8:0] e;
        if (!rst_n) begin
            pstall8 = 1'b0;
            pv8     = 1'b0;
        end else begin
            if (pstall8) begin
                check("hold_valid8", ov8, 1);
                check("hold_data8", od8, pd8);
                check("hold_last8", ol8, pl8);
            end
            if (bz8) check("in_ready_busy8", ir8, 0);
            if (ov8 && !pv8) check("latency8", cyc - hs8, 13);
            if (ov8 && or8) begin
                if (q8.size() == 0) begin
                    check("spurious_out8", q8.size(), 1);
                end else begin
                    e = q8.pop_front();
                    $display("dut8 out: data=%0d last=%0d exp_data=%0d exp_last=%0d", od8, ol8, e[7:0], e[8]);
                    check("data8", od8, e[7:0]);
                    check("last8", ol8, e[8]);
                end
            end
            pstall8 = ov8 && !or8;
            pd8     = od8;
            pl8     = ol8;
            pv8     = ov8;
        end
    end

    // Monitor, N=4
    logic pv4 = 1'b0;
    always @(negedge clk) begin
        logic [8:0] e;
        if (!rst_n) begin
            pv4 = 1'b0;
        end else begin
            if (bz4) check("in_ready_busy4", ir4, 0);
            if (ov4 && !pv4) check("latency4", cyc - hs4, 5);
            if (ov4 && or4) begin
                if (q4.size() == 0) begin
                    check("spurious_out4", q4.size(), 1);
                end else begin
                    e = q4.pop_front();
                    $display("dut4 out: data=%0d last=%0d exp_data=%0d exp_last=%0d", od4, ol4, e[7:0], e[8]);
                    check("data4", od4, e[7:0]);
                    check("last4", ol4, e[8]);
                end
            end
            pv4 = ov4;
        end
    end

    task automatic push8();
        for (int i = 0; i < 8; i++) q8.push_back({(i == 7), exp8[i]});
    endtask

    task automatic push4();
        for (int i = 0; i < 4; i++) q4.push_back({(i == 3), exp4[i]});
    endtask

    // Called and returning at a negedge.
    task automatic send8();
        for (int i = 0; i < 8; i++) begin
            int t;
            iv8 = 1'b1;
            id8 = vec8[i];
            t = 0;
            while (!ir8 && t < 500) begin
                @(negedge clk);
                t++;
            end
            check("in_ready8", ir8, 1);
            if (i == 7) hs8 = cyc;
            @(negedge clk);
        end
        iv8 = 1'b0;
    endtask

    task automatic send4();
        for (int i = 0; i < 4; i++) begin
            int t;
            iv4 = 1'b1;
            id4 = vec4[i];
            t = 0;
            while (!ir4 && t < 500) begin
                @(negedge clk);
                t++;
            end
            check("in_ready4", ir4, 1);
            if (i == 3) hs4 = cyc;
            @(negedge clk);
        end
        iv4 = 1'b0;
    endtask

    task automatic drain8();
        int t = 0;
        while ((q8.size() != 0 || bz8) && t < 1000) begin
            @(negedge clk);
            t++;
        end
        check("drain8", q8.size(), 0);
    endtask

    task automatic drain4();
        int t = 0;
        while ((q4.size() != 0 || bz4) && t < 1000) begin
            @(negedge clk);
            t++;
        end
        check("drain4", q4.size(), 0);
    endtask

    task automatic cfg_fwd8();
        mod8  = 8'd17;
        om8   = {8'd8, 8'd4, 8'd2, 8'd1};
        inv8  = 1'b0;
        ninv8 = 8'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        iv8 = 1'b0; id8 = '0; iv4 = 1'b0; id4 = '0;
        cfg_fwd8();
        mod4 = 8'd17; om4 = {8'd4, 8'd1}; inv4 = 1'b0; ninv4 = 8'd0;
        or4 = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready8", ir8, 1);
        check("rst_out_valid8", ov8, 0);
        check("rst_out_last8", ol8, 0);
        check("rst_busy8", bz8, 0);
        check("rst_out_data8", od8, 0);
        check("rst_in_ready4", ir4, 1);
        check("rst_out_valid4", ov4, 0);

        // Forward NTT of a delta at index 1
        vec8 = '{8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        exp8 = '{8'd1, 8'd2, 8'd4, 8'd8, 8'd16, 8'd15, 8'd13, 8'd9};
        push8();
        send8();
        drain8();

        // All ones; config for the next frame changes while this one computes
        vec8 = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1};
        exp8 = '{8'd8, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        push8();
        send8();
        om8   = {8'd15, 8'd13, 8'd9, 8'd1};
        inv8  = 1'b1;
        ninv8 = 8'd15;
        drain8();

        // Inverse NTT recovers the delta
        vec8 = '{8'd1, 8'd2, 8'd4, 8'd8, 8'd16, 8'd15, 8'd13, 8'd9};
        exp8 = '{8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        push8();
        send8();
        drain8();

        // Backpressure on the forward delta frame
        cfg_fwd8();
        bp8  = 1'b1;
        vec8 = '{8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        exp8 = '{8'd1, 8'd2, 8'd4, 8'd8, 8'd16, 8'd15, 8'd13, 8'd9};
        push8();
        send8();
        drain8();
        bp8 = 1'b0;
        @(negedge clk);

        // Reset during COMPUTE aborts the frame without output
        vec8 = '{8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        send8();
        repeat (4) @(negedge clk);
        check("mid_busy8", bz8, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_in_ready8", ir8, 1);
        check("abort_out_valid8", ov8, 0);
        check("abort_busy8", bz8, 0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("abort_idle8", ov8, 0);
        vec8 = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1};
        exp8 = '{8'd8, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        push8();
        send8();
        drain8();

        // N=4 instance, two frames back to back
        vec4 = '{8'd1, 8'd1, 8'd1, 8'd1};
        exp4 = '{8'd4, 8'd0, 8'd0, 8'd0};
        push4();
        send4();
        vec4 = '{8'd0, 8'd1, 8'd0, 8'd0};
        exp4 = '{8'd1, 8'd4, 8'd16, 8'd13};
        push4();
        send4();
        drain4();

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
